reaction_timer_avg: RTL and testbench
=====================================

REACTION_TIMER_AVG -- requirements
Module: reaction_timer_avg

Interface
REQ-001 Parameter CLK_FREQ_HZ, 100_000_000, clk frequency; ms tick divisor TICK_DIV = CLK_FREQ_HZ/1000.
REQ-002 Parameter ROUNDS, 4, trials per set; SHALL be a power of two, 2..8.
REQ-003 Parameter MIN_DELAY_MS, 2000, minimum random wait.
REQ-004 Parameter DELAY_RANGE_LOG2, 12, random wait adds 0..2^DELAY_RANGE_LOG2-1 ms.
REQ-005 Parameter MAX_MS, 9999, timeout ceiling; SHALL be at most 9999.
REQ-006 Parameter REFRESH_DIV, 100_000, clk cycles per display digit.
REQ-007 clk  in  1  single clock; all logic on rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-low.
REQ-009 start  in  1  debounced level; rising edge begins a trial.
REQ-010 stop  in  1  debounced level; rising edge is the reaction press.
REQ-011 clear  in  1  debounced level; high discards all results.
REQ-012 SW  in  16  SW[1:0] display select (00 last, 01 average, 10 best, 11 round count); SW[15:2] unused.
REQ-013 an  out  8  digit enables, active-low; an[7:4] always 1.
REQ-014 sseg  out  8  segments {dp,g..a}, active-low; dp always 1.
REQ-015 led  out  1  stimulus lamp, high only in ARMED.
REQ-016 LED  out  16  [3:0] completed rounds, [14] last-trial timeout, [15] last-trial early press, others 0.

Function
REQ-017 Edge detect: edge = level & ~prev; prev registers reset to 1, so levels held through reset produce no edge.
REQ-018 ms tick: one-cycle pulse every TICK_DIV clocks; divider cleared on every state entry.
REQ-019 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1, advances every clock, never all-zero.
REQ-020 States: IDLE, WAIT, ARMED, DONE, FAULT, SUMMARY.
REQ-021 IDLE/DONE/FAULT + start edge -> WAIT; delay = MIN_DELAY_MS + LFSR[DELAY_RANGE_LOG2-1:0] sampled that cycle; LED[15:14] cleared.
REQ-022 SUMMARY + start edge -> WAIT with sum, best, round count cleared (new set).
REQ-023 WAIT: delay decrements per tick; stop edge -> FAULT, LED[15]=1, round not counted; delay reaching 0 -> ARMED, ms counter = 0.
REQ-024 ARMED: ms counter increments per tick; stop edge -> capture ms counter as last; ms counter reaching MAX_MS -> capture MAX_MS, LED[14]=1; either case -> DONE, or SUMMARY if it was round ROUNDS.
REQ-025 On capture: sum += last (width sized for ROUNDS*MAX_MS, no overflow); rounds += 1; best = min(best, last), best reset value MAX_MS.
REQ-026 average = sum >> log2(ROUNDS), truncating; valid only in SUMMARY, shows 0 otherwise.
REQ-027 start edge in WAIT or ARMED ignored; stop edge in IDLE, DONE, FAULT, SUMMARY ignored.
REQ-028 start and stop edges in same cycle: state's own rule applies (ARMED takes stop; IDLE takes start).
REQ-029 clear high, any state: next cycle IDLE, last/sum/rounds/average = 0, best = MAX_MS, LED = 0, led = 0; clear overrides all simultaneous edges.
REQ-030 Display: selected value converted to 4 BCD digits (combinational double-dabble), digit k on an[k], refreshed round-robin every REFRESH_DIV clocks, standard hex-free 0-9 decode.
REQ-031 led changes in the same cycle the state register enters/leaves ARMED (registered output).

Reset
REQ-032 rst low: state IDLE, LFSR 16'hACE1, all counters 0, best MAX_MS, led 0, LED 0, an 8'hFE, sseg shows "0" (8'hC0).
REQ-033 rst low mid-trial aborts immediately; no partial result captured.

Verification (CLK_FREQ_HZ=10_000, MIN_DELAY_MS=2, DELAY_RANGE_LOG2=2, MAX_MS=50, ROUNDS=2, REFRESH_DIV=4)
REQ-034 Reset, start edge, stop edge 7 ticks after led rises -> led 0, SW=00 shows 0007, LED[3:0]=1.
REQ-035 Two trials of 7 and 12 ms -> SUMMARY, SW=01 shows 0009, SW=10 shows 0007, LED[3:0]=2.
REQ-036 stop edge during WAIT -> FAULT, LED[15]=1, led never rises, rounds unchanged.
REQ-037 No stop for 50 ticks after led rises -> last=0050, LED[14]=1, led 0.
REQ-038 clear pulse while ARMED with start and stop edges same cycle -> IDLE, displays 0000, LED 0.
REQ-039 Start held high through rst release -> remains IDLE until release-and-repress; rst asserted in ARMED -> outputs match REQ-032 within the same cycle.

Source files
------------

// File: rtl/reaction_timer_avg_if.sv
// Front-panel bundle for the reaction timer: debounced buttons and switches in,
// seven-segment display and lamps out.
interface reaction_timer_avg_if;
  logic        start;
  logic        stop;
  logic        clear;
  logic [15:0] SW;
  logic [7:0]  an;
  logic [7:0]  sseg;
  logic        led;
  logic [15:0] LED;

  modport master (
    output start, stop, clear, SW,
    input  an, sseg, led, LED
  );

  modport slave (
    input  start, stop, clear, SW,
    output an, sseg, led, LED
  );
endinterface

// File: rtl/reaction_timer_avg.sv
// Reaction timer: random wait, lamp, timed press; keeps last, best and a per-set
// average over ROUNDS trials, shown on a 4-digit multiplexed seven-segment display.
module reaction_timer_avg #(
  parameter int unsigned CLK_FREQ_HZ      = 100_000_000,
  parameter int unsigned ROUNDS           = 4,
  parameter int unsigned MIN_DELAY_MS     = 2000,
  parameter int unsigned DELAY_RANGE_LOG2 = 12,
  parameter int unsigned MAX_MS           = 9999,
  parameter int unsigned REFRESH_DIV      = 100_000
) (
  input logic                 clk,
  input logic                 rst,
  reaction_timer_avg_if.slave bus
);

  localparam int unsigned TICK_DIV = CLK_FREQ_HZ / 1000;
  localparam int unsigned TW       = $clog2(TICK_DIV + 1);
  localparam int unsigned MSW      = $clog2(MAX_MS + 1);
  localparam int unsigned DW       = $clog2(MIN_DELAY_MS + (1 << DELAY_RANGE_LOG2) + 1);
  localparam int unsigned SUMW     = $clog2(ROUNDS * MAX_MS + 1);
  localparam int unsigned RFW      = $clog2(REFRESH_DIV + 1);
  localparam int unsigned AVG_SH   = $clog2(ROUNDS);

  typedef enum logic [2:0] {
    StIdle, StWait, StArmed, StDone, StFault, StSummary
  } state_e;

  state_e          r_state, w_state_nxt;
  logic            r_start_prev, r_stop_prev;
  logic [15:0]     r_lfsr;
  logic [TW-1:0]   r_tick_cnt;
  logic [DW-1:0]   r_delay, w_delay_nxt;
  logic [MSW-1:0]  r_ms, w_ms_nxt;
  logic [MSW-1:0]  r_last, w_last_nxt;
  logic [MSW-1:0]  r_best, w_best_nxt;
  logic [SUMW-1:0] r_sum, w_sum_nxt;
  logic [3:0]      r_rounds, w_rounds_nxt;
  logic            r_early, w_early_nxt;
  logic            r_tout, w_tout_nxt;
  logic            r_led;
  logic [RFW-1:0]  r_ref_cnt;
  logic [1:0]      r_digit;

  logic            w_start_edge, w_stop_edge, w_tick;
  logic            w_capture;
  logic [MSW-1:0]  w_cap_val;
  logic [DW-1:0]   w_new_delay;
  logic [SUMW-1:0] w_avg;
  logic [13:0]     w_disp;
  logic [29:0]     w_dd;
  logic [15:0]     w_bcd;
  logic [3:0]      w_digit_val;
  logic            w_unused_sw;

  assign w_start_edge = bus.start & ~r_start_prev;
  assign w_stop_edge  = bus.stop & ~r_stop_prev;
  assign w_tick       = (r_tick_cnt == TW'(TICK_DIV - 1));
  assign w_new_delay  = DW'(MIN_DELAY_MS) + DW'(r_lfsr[DELAY_RANGE_LOG2-1:0]);
  assign w_avg        = r_sum >> AVG_SH;
  assign w_unused_sw  = ^bus.SW[15:2];

  always_comb begin
    w_state_nxt  = r_state;
    w_delay_nxt  = r_delay;
    w_ms_nxt     = r_ms;
    w_last_nxt   = r_last;
    w_sum_nxt    = r_sum;
    w_best_nxt   = r_best;
    w_rounds_nxt = r_rounds;
    w_early_nxt  = r_early;
    w_tout_nxt   = r_tout;
    w_capture    = 1'b0;
    w_cap_val    = '0;
    if (bus.clear) begin
      w_state_nxt  = StIdle;
      w_delay_nxt  = '0;
      w_ms_nxt     = '0;
      w_last_nxt   = '0;
      w_sum_nxt    = '0;
      w_best_nxt   = MSW'(MAX_MS);
      w_rounds_nxt = '0;
      w_early_nxt  = 1'b0;
      w_tout_nxt   = 1'b0;
    end else begin
      unique case (r_state)
        StIdle, StDone, StFault: begin
          if (w_start_edge) begin
            w_state_nxt = StWait;
            w_delay_nxt = w_new_delay;
            w_early_nxt = 1'b0;
            w_tout_nxt  = 1'b0;
          end
        end
        StSummary: begin
          if (w_start_edge) begin
            w_state_nxt  = StWait;
            w_delay_nxt  = w_new_delay;
            w_early_nxt  = 1'b0;
            w_tout_nxt   = 1'b0;
            w_sum_nxt    = '0;
            w_best_nxt   = MSW'(MAX_MS);
            w_rounds_nxt = '0;
          end
        end
        StWait: begin
          if (w_stop_edge) begin
            w_state_nxt = StFault;
            w_early_nxt = 1'b1;
          end else if (w_tick) begin
            if (r_delay <= DW'(1)) begin
              w_state_nxt = StArmed;
              w_delay_nxt = '0;
              w_ms_nxt    = '0;
            end else begin
              w_delay_nxt = r_delay - DW'(1);
            end
          end
        end
        StArmed: begin
          if (w_stop_edge) begin
            w_capture = 1'b1;
            w_cap_val = r_ms;
          end else if (w_tick) begin
            if (r_ms >= MSW'(MAX_MS - 1)) begin
              w_capture  = 1'b1;
              w_cap_val  = MSW'(MAX_MS);
              w_tout_nxt = 1'b1;
            end else begin
              w_ms_nxt = r_ms + MSW'(1);
            end
          end
        end
        default: w_state_nxt = StIdle;
      endcase
      if (w_capture) begin
        w_last_nxt   = w_cap_val;
        w_sum_nxt    = r_sum + SUMW'(w_cap_val);
        w_rounds_nxt = r_rounds + 4'd1;
        w_best_nxt   = (w_cap_val < r_best) ? w_cap_val : r_best;
        w_state_nxt  = ((r_rounds + 4'd1) == 4'(ROUNDS)) ? StSummary : StDone;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= StIdle;
      r_start_prev <= 1'b1;
      r_stop_prev  <= 1'b1;
      r_lfsr       <= 16'hACE1;
      r_tick_cnt   <= '0;
      r_delay      <= '0;
      r_ms         <= '0;
      r_last       <= '0;
      r_sum        <= '0;
      r_best       <= MSW'(MAX_MS);
      r_rounds     <= '0;
      r_early      <= 1'b0;
      r_tout       <= 1'b0;
      r_led        <= 1'b0;
      r_ref_cnt    <= '0;
      r_digit      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_start_prev <= bus.start;
      r_stop_prev  <= bus.stop;
      // Taps 16,14,13,11; a nonzero seed never reaches the all-zero lockup state
      r_lfsr       <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      r_tick_cnt   <= ((w_state_nxt != r_state) || w_tick) ? '0 : r_tick_cnt + TW'(1);
      r_delay      <= w_delay_nxt;
      r_ms         <= w_ms_nxt;
      r_last       <= w_last_nxt;
      r_sum        <= w_sum_nxt;
      r_best       <= w_best_nxt;
      r_rounds     <= w_rounds_nxt;
      r_early      <= w_early_nxt;
      r_tout       <= w_tout_nxt;
      r_led        <= (w_state_nxt == StArmed);
      if (r_ref_cnt == RFW'(REFRESH_DIV - 1)) begin
        r_ref_cnt <= '0;
        r_digit   <= r_digit + 2'd1;
      end else begin
        r_ref_cnt <= r_ref_cnt + RFW'(1);
      end
    end
  end

  always_comb begin
    unique case (bus.SW[1:0])
      2'b00:   w_disp = 14'(r_last);
      2'b01:   w_disp = (r_state == StSummary) ? 14'(w_avg) : 14'd0;
      2'b10:   w_disp = 14'(r_best);
      default: w_disp = 14'(r_rounds);
    endcase
  end

  // Shift-add-3 binary to BCD; values never exceed 9999
  always_comb begin
    w_dd = {16'd0, w_disp};
    for (int i = 0; i < 14; i++) begin
      for (int d = 0; d < 4; d++) begin
        if (w_dd[14+4*d +: 4] >= 4'd5) w_dd[14+4*d +: 4] = w_dd[14+4*d +: 4] + 4'd3;
      end
      w_dd = w_dd << 1;
    end
  end
  assign w_bcd = w_dd[29:14];

  always_comb begin
    unique case (r_digit)
      2'd0:    w_digit_val = w_bcd[3:0];
      2'd1:    w_digit_val = w_bcd[7:4];
      2'd2:    w_digit_val = w_bcd[11:8];
      default: w_digit_val = w_bcd[15:12];
    endcase
  end

  always_comb begin
    unique case (w_digit_val)
      4'd0:    bus.sseg = 8'hC0;
      4'd1:    bus.sseg = 8'hF9;
      4'd2:    bus.sseg = 8'hA4;
      4'd3:    bus.sseg = 8'hB0;
      4'd4:    bus.sseg = 8'h99;
      4'd5:    bus.sseg = 8'h92;
      4'd6:    bus.sseg = 8'h82;
      4'd7:    bus.sseg = 8'hF8;
      4'd8:    bus.sseg = 8'h80;
      4'd9:    bus.sseg = 8'h90;
      default: bus.sseg = 8'hFF;
    endcase
  end

  assign bus.an  = {4'hF, ~(4'b0001 << r_digit)};
  assign bus.led = r_led;
  assign bus.LED = {r_early, r_tout, 10'd0, r_rounds};

endmodule

// File: tb/tb_reaction_timer_avg.sv
// Self-checking bench for reaction_timer_avg: table of trials with a scoreboard of
// expected results, plus hand-written clear and reset sequences.
module tb_reaction_timer_avg;

  localparam int unsigned ROUNDS = 2;
  localparam int unsigned MAX_MS = 50;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  reaction_timer_avg_if bus_if ();

  reaction_timer_avg #(
    .CLK_FREQ_HZ     (10_000),
    .ROUNDS          (ROUNDS),
    .MIN_DELAY_MS    (2),
    .DELAY_RANGE_LOG2(2),
    .MAX_MS          (MAX_MS),
    .REFRESH_DIV     (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  // press_ms: >=0 press after that many ms of lamp, -1 never press, -2 press during wait
  typedef struct {
    int press_ms;
    int exp_last;
    int exp_rounds;
    bit exp_to;
    bit exp_early;
  } trial_t;

  trial_t trials[5];
  trial_t sb_q[$];

  int m_sum;
  int m_best;
  int m_rounds;
  bit m_summary;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int seg2dig(input logic [7:0] s);
    case (s)
      8'hC0:   return 0;
      8'hF9:   return 1;
      8'hA4:   return 2;
      8'hB0:   return 3;
      8'h99:   return 4;
      8'h92:   return 5;
      8'h82:   return 6;
      8'hF8:   return 7;
      8'h80:   return 8;
      8'h90:   return 9;
      default: return -1;
    endcase
  endfunction

  // Scans one full refresh cycle; returns -1 if any digit is missing or undecodable
  task automatic read_disp(input logic [1:0] sel, output int val);
    int dig[4];
    bit seen[4];
    bus_if.SW = {14'd0, sel};
    for (int k = 0; k < 4; k++) begin
      dig[k]  = -1;
      seen[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (bus_if.an[k] == 1'b0) begin
          dig[k]  = seg2dig(bus_if.sseg);
          seen[k] = 1'b1;
        end
      end
    end
    val = 0;
    for (int k = 3; k >= 0; k--) begin
      if (!seen[k] || dig[k] < 0) val = -1;
      else if (val >= 0) val = val * 10 + dig[k];
    end
  endtask

  task automatic run_trial(input int idx, input trial_t t);
    bit     hit;
    int     v;
    trial_t e;
    if (m_summary) begin
      m_sum     = 0;
      m_best    = MAX_MS;
      m_rounds  = 0;
      m_summary = 1'b0;
    end
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    if (t.press_ms == -2) begin
      repeat (5) @(negedge clk);
      sb_q.push_back(t);
      bus_if.stop = 1'b1;
      @(negedge clk);
      bus_if.stop = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (bus_if.led) hit = 1'b1;
      end
      check($sformatf("t%0d_led_after_early", idx), int'(hit), 0);
    end else begin
      hit = 1'b0;
      for (int c = 0; c < 200 && !hit; c++) begin
        @(negedge clk);
        hit = bus_if.led;
      end
      check($sformatf("t%0d_led_rise", idx), int'(hit), 1);
      if (t.press_ms >= 0) begin
        repeat (t.press_ms * 10 + 5) @(negedge clk);
        sb_q.push_back(t);
        bus_if.stop = 1'b1;
        @(negedge clk);
        bus_if.stop = 1'b0;
      end else begin
        sb_q.push_back(t);
      end
      hit = 1'b0;
      for (int c = 0; c < 700 && !hit; c++) begin
        @(negedge clk);
        hit = !bus_if.led;
      end
      check($sformatf("t%0d_led_fall", idx), int'(hit), 1);
      m_rounds++;
      m_sum += t.exp_last;
      if (t.exp_last < m_best) m_best = t.exp_last;
      if (m_rounds == ROUNDS) m_summary = 1'b1;
    end
    if (sb_q.size() == 0) begin
      check($sformatf("t%0d_scoreboard_empty", idx), 0, 1);
    end else begin
      e = sb_q.pop_front();
      read_disp(2'b00, v);
      check($sformatf("t%0d_last", idx), v, e.exp_last);
      check($sformatf("t%0d_LED_rounds", idx), int'(bus_if.LED[3:0]), e.exp_rounds);
      check($sformatf("t%0d_LED_timeout", idx), int'(bus_if.LED[14]), int'(e.exp_to));
      check($sformatf("t%0d_LED_early", idx), int'(bus_if.LED[15]), int'(e.exp_early));
      check($sformatf("t%0d_led_low", idx), int'(bus_if.led), 0);
      read_disp(2'b01, v);
      check($sformatf("t%0d_avg", idx), v, m_summary ? (m_sum >> $clog2(ROUNDS)) : 0);
      read_disp(2'b10, v);
      check($sformatf("t%0d_best", idx), v, m_best);
      read_disp(2'b11, v);
      check($sformatf("t%0d_round_disp", idx), v, e.exp_rounds);
    end
  endtask

  initial begin
    bit hit;
    int v;
    n_tests   = 0;
    n_fail    = 0;
    m_sum     = 0;
    m_best    = MAX_MS;
    m_rounds  = 0;
    m_summary = 1'b0;

    trials[0] = '{7, 7, 1, 1'b0, 1'b0};
    trials[1] = '{12, 12, 2, 1'b0, 1'b0};
    trials[2] = '{7, 7, 1, 1'b0, 1'b0};
    trials[3] = '{-2, 7, 1, 1'b0, 1'b1};
    trials[4] = '{-1, 50, 2, 1'b1, 1'b0};

    rst          = 1'b0;
    bus_if.start = 1'b0;
    bus_if.stop  = 1'b0;
    bus_if.clear = 1'b0;
    bus_if.SW    = 16'd0;
    repeat (3) @(negedge clk);
    check("reset_an", int'(bus_if.an), 'hFE);
    check("reset_sseg", int'(bus_if.sseg), 'hC0);
    check("reset_led", int'(bus_if.led), 0);
    check("reset_LED", int'(bus_if.LED), 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 5; i++) run_trial(i, trials[i]);

    // Clear while armed, with start and stop edges in the same cycle
    bus_if.SW    = 16'd0;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      hit = bus_if.led;
    end
    check("clr_led_rise", int'(hit), 1);
    bus_if.clear = 1'b1;
    bus_if.start = 1'b1;
    bus_if.stop  = 1'b1;
    @(negedge clk);
    check("clr_led", int'(bus_if.led), 0);
    check("clr_LED", int'(bus_if.LED), 0);
    bus_if.clear = 1'b0;
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.stop  = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus_if.led) hit = 1'b1;
    end
    check("clr_stays_idle", int'(hit), 0);
    read_disp(2'b00, v);
    check("clr_last", v, 0);
    read_disp(2'b01, v);
    check("clr_avg", v, 0);
    read_disp(2'b10, v);
    check("clr_best", v, MAX_MS);
    read_disp(2'b11, v);
    check("clr_rounds", v, 0);
    bus_if.SW = 16'd0;

    // Start held through reset release must not count as an edge
    rst          = 1'b0;
    bus_if.start = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus_if.led) hit = 1'b1;
    end
    check("held_start_no_trial", int'(hit), 0);
    bus_if.start = 1'b0;
    @(negedge clk);
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      hit = bus_if.led;
    end
    check("repress_led_rise", int'(hit), 1);

    // Asynchronous reset while armed
    rst = 1'b0;
    #1;
    check("arst_led", int'(bus_if.led), 0);
    check("arst_LED", int'(bus_if.LED), 0);
    check("arst_an", int'(bus_if.an), 'hFE);
    check("arst_sseg", int'(bus_if.sseg), 'hC0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
